lieat_sram_rd_arb: RTL and testbench

- Read-channel arbiter that shares the single SRAM AXI read port (AR/R, sram_axi_* style) between NUM_MST requesters, e.g. IFU fetch and LSU load.
- Sits between the core-side requesters and lieat_axi_slave/lieat_sram.
- One outstanding read at a time; arbitrates, latches the request, issues it downstream and steers the response back to the granted requester.
- Write channels bypass this block.

---
 rtl/lieat_sram_rd_arb_pkg.sv | 23 ++
 rtl/lieat_rr_arbiter.sv | 35 +++
 rtl/lieat_sram_rd_arb.sv | 136 +++++++++++++
 tb/tb_lieat_sram_rd_arb.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/lieat_sram_rd_arb_pkg.sv
// Shared constants and types for the SRAM read-channel arbiter and its helper arbiter.
package lieat_sram_rd_arb_pkg;

  localparam int ID_W    = 4;
  localparam int MAX_MST = 4;

  localparam logic [2:0] AXI_SIZE_1B = 3'd0;
  localparam logic [2:0] AXI_SIZE_2B = 3'd1;
  localparam logic [2:0] AXI_SIZE_4B = 3'd2;
  localparam logic [2:0] AXI_SIZE_8B = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_e;

  // Index width for up to MAX_MST requesters.
  function automatic int idx_w(input int n);
    return (n > 2) ? 2 : 1;
  endfunction

endpackage

// File: rtl/lieat_rr_arbiter.sv
// Combinational rotating-priority arbiter: the search starts at ptr_i and wraps.
// A ptr_i tied to zero degenerates to fixed lowest-index priority.
module lieat_rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             vld_o
);

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    // First pass covers [ptr, N), second pass wraps over [0, ptr).
    for (int j = 0; j < N; j++) begin
      if (!vld_o && (j >= int'(ptr_i)) && req_i[j]) begin
        vld_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IDX_W'(j);
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!vld_o && (j < int'(ptr_i)) && req_i[j]) begin
        vld_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/lieat_sram_rd_arb.sv
// Shares one SRAM AXI read port between NUM_MST requesters, one read in flight.
// Build option LIEAT_ARB_RR_EN selects round-robin; otherwise fixed lowest-index priority.
module lieat_sram_rd_arb
  import lieat_sram_rd_arb_pkg::*;
#(
  parameter int NUM_MST = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NUM_MST-1:0]      m_arvalid,
  output logic [NUM_MST-1:0]      m_arready,
  input  logic [NUM_MST*ADDR_W-1:0] m_araddr,
  input  logic [NUM_MST*3-1:0]    m_arsize,
  output logic [NUM_MST-1:0]      m_rvalid,
  input  logic [NUM_MST-1:0]      m_rready,
  output logic [DATA_W-1:0]       m_rdata,
  output logic                    m_rerr,
  output logic                    sram_axi_arvalid,
  input  logic                    sram_axi_arready,
  output logic [31:0]             sram_axi_araddr,
  output logic [2:0]              sram_axi_arsize,
  output logic [ID_W-1:0]         sram_axi_arid,
  input  logic                    sram_axi_rvalid,
  output logic                    sram_axi_rready,
  input  logic [31:0]             sram_axi_rdata,
  input  logic [ID_W-1:0]         sram_axi_rid
);

  localparam int IDX_W = idx_w(NUM_MST);

  arb_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]       size_q, size_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic             rerr_q, rerr_d;

  logic [NUM_MST-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_vld;
  logic [IDX_W-1:0]   ptr;
  logic [NUM_MST-1:0] arready_c;

  lieat_rr_arbiter #(.N(NUM_MST), .IDX_W(IDX_W)) u_arb (
    .req_i (m_arvalid),
    .ptr_i (ptr),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .vld_o (arb_vld)
  );

`ifdef LIEAT_ARB_RR_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == ST_IDLE && arb_vld)
      ptr_d = IDX_W'((int'(arb_idx) + 1) % NUM_MST);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    size_d           = size_q;
    grant_d          = grant_q;
    rerr_d           = 1'b0;
    arready_c        = '0;
    sram_axi_arvalid = 1'b0;
    sram_axi_rready  = 1'b0;
    m_rvalid         = '0;
    m_rdata          = '0;
    case (state_q)
      ST_IDLE: begin
        rerr_d = sram_axi_rvalid;
        if (arb_vld) begin
          arready_c = arb_gnt;
          addr_d    = m_araddr[int'(arb_idx)*ADDR_W +: ADDR_W];
          size_d    = m_arsize[int'(arb_idx)*3 +: 3];
          grant_d   = arb_idx;
          state_d   = ST_ADDR;
        end
      end
      ST_ADDR: begin
        rerr_d           = sram_axi_rvalid;
        sram_axi_arvalid = 1'b1;
        if (sram_axi_arready) state_d = ST_DATA;
      end
      ST_DATA: begin
        sram_axi_rready   = m_rready[grant_q];
        m_rvalid[grant_q] = sram_axi_rvalid;
        m_rdata           = DATA_W'(sram_axi_rdata);
        // Flag a wrong ID once, on the completing beat; the beat is still delivered.
        if (sram_axi_rvalid && m_rready[grant_q]) begin
          rerr_d  = (sram_axi_rid != ID_W'(grant_q));
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Arbitration is combinational, so keep the grant quiet while reset is held.
  assign m_arready       = arready_c & {NUM_MST{rstn}};
  assign sram_axi_araddr = 32'(addr_q);
  assign sram_axi_arsize = size_q;
  assign sram_axi_arid   = ID_W'(grant_q);
  assign m_rerr          = rerr_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      grant_q <= '0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      grant_q <= grant_d;
      rerr_q  <= rerr_d;
    end
  end

endmodule

// File: tb/tb_lieat_sram_rd_arb.sv
// Directed plus randomized bench for lieat_sram_rd_arb against a transaction-level model.
module tb_lieat_sram_rd_arb;

  localparam int NUM_MST = 2;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;

  logic                      clk = 1'b0;
  logic                      rstn;
  logic [NUM_MST-1:0]        m_arvalid;
  logic [NUM_MST-1:0]        m_arready;
  logic [NUM_MST*ADDR_W-1:0] m_araddr;
  logic [NUM_MST*3-1:0]      m_arsize;
  logic [NUM_MST-1:0]        m_rvalid;
  logic [NUM_MST-1:0]        m_rready;
  logic [DATA_W-1:0]         m_rdata;
  logic                      m_rerr;
  logic                      sram_axi_arvalid;
  logic                      sram_axi_arready;
  logic [31:0]               sram_axi_araddr;
  logic [2:0]                sram_axi_arsize;
  logic [3:0]                sram_axi_arid;
  logic                      sram_axi_rvalid;
  logic                      sram_axi_rready;
  logic [31:0]               sram_axi_rdata;
  logic [3:0]                sram_axi_rid;

  int errors = 0;
  int checks = 0;
  int ptr_m  = 0;

  lieat_sram_rd_arb #(.NUM_MST(NUM_MST), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rstn(rstn),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arsize(m_arsize),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rerr(m_rerr),
    .sram_axi_arvalid(sram_axi_arvalid), .sram_axi_arready(sram_axi_arready),
    .sram_axi_araddr(sram_axi_araddr), .sram_axi_arsize(sram_axi_arsize),
    .sram_axi_arid(sram_axi_arid), .sram_axi_rvalid(sram_axi_rvalid),
    .sram_axi_rready(sram_axi_rready), .sram_axi_rdata(sram_axi_rdata),
    .sram_axi_rid(sram_axi_rid)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NUM_MST-1:0] onehot(input int g);
    logic [NUM_MST-1:0] v;
    v = '0;
    v[g] = 1'b1;
    return v;
  endfunction

  // Who should win among the requesting set, by the priority rule of this build.
  function automatic int pick(input logic [NUM_MST-1:0] req);
`ifdef LIEAT_ARB_RR_EN
    for (int k = 0; k < NUM_MST; k++)
      if (req[(ptr_m + k) % NUM_MST]) return (ptr_m + k) % NUM_MST;
`else
    for (int k = 0; k < NUM_MST; k++)
      if (req[k]) return k;
`endif
    return -1;
  endfunction

  task automatic set_req(input int m, input logic [31:0] a, input logic [2:0] s);
    m_arvalid[m]        = 1'b1;
    m_araddr[m*32 +: 32] = a;
    m_arsize[m*3 +: 3]   = s;
  endtask

  // Entered in IDLE at posedge+1 with requests applied; returns at posedge+1 after the R handshake.
  task automatic serve(input int ar_wait, input int r_wait, input bit bad_id,
                       input logic [31:0] data, output int g);
    logic [31:0] ea;
    logic [2:0]  es;
    logic [3:0]  rid_v;
    g  = pick(m_arvalid);
    ea = m_araddr[g*32 +: 32];
    es = m_arsize[g*3 +: 3];
    #1;
    chk("idle_arready", m_arready, onehot(g));
    chk("idle_arvalid", sram_axi_arvalid, 1'b0);
    @(posedge clk); #1;
`ifdef LIEAT_ARB_RR_EN
    ptr_m = (g + 1) % NUM_MST;
`endif
    m_arvalid[g] = 1'b0;
    for (int i = 0; i <= ar_wait; i++) begin
      sram_axi_arready = (i == ar_wait);
      #1;
      chk("ar_valid", sram_axi_arvalid, 1'b1);
      chk("ar_addr", sram_axi_araddr, ea);
      chk("ar_size", sram_axi_arsize, es);
      chk("ar_id", sram_axi_arid, 4'(g));
      chk("ar_m_arready", m_arready, '0);
      @(posedge clk); #1;
    end
    sram_axi_arready = 1'b0;
    rid_v = bad_id ? (4'(g) ^ 4'hC) : 4'(g);
    sram_axi_rvalid = 1'b1;
    sram_axi_rdata  = data;
    sram_axi_rid    = rid_v;
    for (int i = 0; i <= r_wait; i++) begin
      m_rready = ~onehot(g) | ((i == r_wait) ? onehot(g) : '0);
      #1;
      chk("r_rvalid", m_rvalid, onehot(g));
      chk("r_rdata", m_rdata, data);
      chk("r_rready", sram_axi_rready, (i == r_wait));
      chk("r_rerr_quiet", m_rerr, 1'b0);
      @(posedge clk); #1;
    end
    sram_axi_rvalid = 1'b0;
    m_rready        = '0;
    chk("rerr_pulse", m_rerr, bad_id);
  endtask

  initial begin
    int g;
    int rem [NUM_MST];
    rstn             = 1'b0;
    m_arvalid        = '0;
    m_araddr         = '0;
    m_arsize         = '0;
    m_rready         = '0;
    sram_axi_arready = 1'b0;
    sram_axi_rvalid  = 1'b0;
    sram_axi_rdata   = '0;
    sram_axi_rid     = '0;

    // Reset state, with a request already waiting on the inputs.
    set_req(1, 32'h1111_2222, 3'd2);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_arready", m_arready, '0);
    chk("rst_arvalid", sram_axi_arvalid, 1'b0);
    chk("rst_araddr", sram_axi_araddr, 32'h0);
    chk("rst_arid", sram_axi_arid, 4'h0);
    chk("rst_arsize", sram_axi_arsize, 3'h0);
    chk("rst_rvalid", m_rvalid, '0);
    chk("rst_rready", sram_axi_rready, 1'b0);
    chk("rst_rdata", m_rdata, '0);
    chk("rst_rerr", m_rerr, 1'b0);
    m_arvalid = '0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;

    // Single requester, no stalls.
    set_req(1, 32'h8000_0010, 3'd2);
    serve(0, 0, 1'b0, 32'hDEAD_BEEF, g);

    // Both requesters, four requests each.
    rem[0] = 4; rem[1] = 4;
    set_req(0, 32'h0000_1000, 3'd2);
    set_req(1, 32'h0000_2000, 3'd1);
    for (int t = 0; t < 8; t++) begin
      serve(0, 0, 1'b0, $urandom, g);
      rem[g]--;
      if (rem[g] > 0) set_req(g, 32'h0000_1000 * (g + 1) + 32'(t * 4), 3'd2);
    end

    // Backpressure on both AR and R.
    set_req(0, 32'hA5A5_0040, 3'd2);
    serve(5, 3, 1'b0, 32'h0123_4567, g);
    @(posedge clk); #1;
    chk("bp_one_txn_arvalid", sram_axi_arvalid, 1'b0);
    chk("bp_one_txn_rready", sram_axi_rready, 1'b0);

    // Wrong response ID: delivered anyway, one error pulse.
    set_req(0, 32'h0000_0300, 3'd2);
    serve(0, 0, 1'b1, 32'hCAFE_F00D, g);
    @(posedge clk); #1;
    chk("idmm_pulse_end", m_rerr, 1'b0);
    chk("idmm_idle", sram_axi_arvalid, 1'b0);

    // Stray response while idle.
    sram_axi_rvalid = 1'b1;
    sram_axi_rid    = 4'h0;
    #1;
    chk("stray_rready", sram_axi_rready, 1'b0);
    chk("stray_rvalid", m_rvalid, '0);
    @(posedge clk); #1;
    sram_axi_rvalid = 1'b0;
    chk("stray_rerr", m_rerr, 1'b1);
    @(posedge clk); #1;
    chk("stray_rerr_end", m_rerr, 1'b0);

    // Reset while in ADDR.
    set_req(0, 32'h1234_5678, 3'd2);
    #1;
    chk("rstaddr_grant", m_arready, onehot(pick(m_arvalid)));
    @(posedge clk); #1;
    m_arvalid = '0;
    chk("rstaddr_inaddr", sram_axi_arvalid, 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    chk("rstaddr_arvalid", sram_axi_arvalid, 1'b0);
    chk("rstaddr_araddr", sram_axi_araddr, 32'h0);
    chk("rstaddr_arid", sram_axi_arid, 4'h0);
    @(posedge clk); #1;
    rstn  = 1'b1;
    ptr_m = 0;
    set_req(1, 32'h0000_0F00, 3'd2);
    serve(1, 1, 1'b0, 32'h5555_AAAA, g);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      for (int m = 0; m < NUM_MST; m++)
        if (!m_arvalid[m] && ($urandom_range(1, 0) == 1))
          set_req(m, $urandom, 3'($urandom_range(2, 0)));
      if (m_arvalid == '0) set_req(0, $urandom, 3'd2);
      serve($urandom_range(2, 0), $urandom_range(2, 0), ($urandom_range(3, 0) == 0), $urandom, g);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
